// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline: ALU ops, writeback source, forwarding selects.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_LUI = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam int REG_X0 = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// RAW forwarding select generation for the execute stage; MEM wins over WB, x0 never forwards.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (reg_write_m && (rd_m != REG_ADDR_W'(REG_X0)) && (rd_m == rs))
      return FWD_MEM;
    else if (reg_write_w && (rd_w != REG_ADDR_W'(REG_X0)) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    forward_a = fwd_sel(rs1_e);
    forward_b = fwd_sel(rs2_e);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, bubble counter
// and the forwarded operand muxes feeding the ALU.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Valid_D_i,
  input  logic [DATA_WIDTH-1:0] RD1_D_i,
  input  logic [DATA_WIDTH-1:0] RD2_D_i,
  input  logic [REG_ADDR_W-1:0] Rs1_D_i,
  input  logic [REG_ADDR_W-1:0] Rs2_D_i,
  input  logic [REG_ADDR_W-1:0] Rd_D_i,
  input  logic [DATA_WIDTH-1:0] ImmExt_D_i,
  input  logic [DATA_WIDTH-1:0] PC_D_i,
  input  logic [2:0]            ALUControl_D_i,
  input  logic                  ALUSrc_D_i,
  input  logic                  RegWrite_D_i,
  input  logic                  MemWrite_D_i,
  input  logic [1:0]            ResultSrc_D_i,
  input  logic                  Branch_D_i,
  input  logic                  Jump_D_i,
  input  logic                  RegWrite_M_i,
  input  logic [REG_ADDR_W-1:0] Rd_M_i,
  input  logic [DATA_WIDTH-1:0] ALUResult_M_i,
  input  logic                  RegWrite_W_i,
  input  logic [REG_ADDR_W-1:0] Rd_W_i,
  input  logic [DATA_WIDTH-1:0] Result_W_i,
  input  logic                  Flush_E_i,
  output logic [DATA_WIDTH-1:0] SrcA_o,
  output logic [DATA_WIDTH-1:0] SrcB_o,
  output logic [2:0]            ALUControl_o,
  output logic [DATA_WIDTH-1:0] WriteData_E_o,
  output logic [REG_ADDR_W-1:0] Rd_E_o,
  output logic [DATA_WIDTH-1:0] PC_E_o,
  output logic [DATA_WIDTH-1:0] ImmExt_E_o,
  output logic                  RegWrite_E_o,
  output logic                  MemWrite_E_o,
  output logic [1:0]            ResultSrc_E_o,
  output logic                  Branch_E_o,
  output logic                  Jump_E_o,
  output logic                  Valid_E_o,
  output logic                  Stall_D_o,
  output logic [CNT_W-1:0]      BubbleCnt_o
);

  logic [DATA_WIDTH-1:0] rd1_p1, rd2_p1, imm_p1, pc_p1;
  logic [REG_ADDR_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [2:0]            alu_ctrl_p1;
  logic                  alu_src_p1, reg_write_p1, mem_write_p1;
  logic [1:0]            result_src_p1;
  logic                  branch_p1, jump_p1, vld_p1;
  logic [CNT_W-1:0]      bubble_cnt;
  logic                  load_use, bubble;
  logic [1:0]            forward_a, forward_b;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A load in E whose rd feeds the instruction in D cannot be forwarded in time.
  always_comb begin
    load_use = Valid_D_i && vld_p1 && reg_write_p1
             && (result_src_p1 == RES_LOAD)
             && (rd_p1 != REG_ADDR_W'(REG_X0))
             && ((rd_p1 == Rs1_D_i) || (rd_p1 == Rs2_D_i));
    bubble   = load_use || Flush_E_i;
  end

  // ---- stage boundary: D -> E ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd1_p1        <= '0;
      rd2_p1        <= '0;
      imm_p1        <= '0;
      pc_p1         <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      rd_p1         <= '0;
      alu_ctrl_p1   <= ALU_ADD;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      result_src_p1 <= RES_ALU;
      branch_p1     <= 1'b0;
      jump_p1       <= 1'b0;
      vld_p1        <= 1'b0;
      bubble_cnt    <= '0;
    end else if (bubble) begin
      rd1_p1        <= '0;
      rd2_p1        <= '0;
      imm_p1        <= '0;
      pc_p1         <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      rd_p1         <= '0;
      alu_ctrl_p1   <= ALU_ADD;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      result_src_p1 <= RES_ALU;
      branch_p1     <= 1'b0;
      jump_p1       <= 1'b0;
      vld_p1        <= 1'b0;
      bubble_cnt    <= sat_inc(bubble_cnt);
    end else begin
      rd1_p1        <= RD1_D_i;
      rd2_p1        <= RD2_D_i;
      imm_p1        <= ImmExt_D_i;
      pc_p1         <= PC_D_i;
      rs1_p1        <= Rs1_D_i;
      rs2_p1        <= Rs2_D_i;
      rd_p1         <= Rd_D_i;
      // An empty decode slot enters E as a NOP: data may flow, controls may not.
      alu_ctrl_p1   <= Valid_D_i ? ALUControl_D_i : ALU_ADD;
      alu_src_p1    <= Valid_D_i && ALUSrc_D_i;
      reg_write_p1  <= Valid_D_i && RegWrite_D_i;
      mem_write_p1  <= Valid_D_i && MemWrite_D_i;
      result_src_p1 <= Valid_D_i ? ResultSrc_D_i : RES_ALU;
      branch_p1     <= Valid_D_i && Branch_D_i;
      jump_p1       <= Valid_D_i && Jump_D_i;
      vld_p1        <= Valid_D_i;
    end
  end

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_forward_unit (
    .rs1_e       (rs1_p1),
    .rs2_e       (rs2_p1),
    .rd_m        (Rd_M_i),
    .reg_write_m (RegWrite_M_i),
    .rd_w        (Rd_W_i),
    .reg_write_w (RegWrite_W_i),
    .forward_a   (forward_a),
    .forward_b   (forward_b)
  );

  // ---- stage boundary: E operand select -> ALU ----
  always_comb begin
    case (forward_a)
      FWD_MEM: fwd_a = ALUResult_M_i;
      FWD_WB:  fwd_a = Result_W_i;
      default: fwd_a = rd1_p1;
    endcase
    case (forward_b)
      FWD_MEM: fwd_b = ALUResult_M_i;
      FWD_WB:  fwd_b = Result_W_i;
      default: fwd_b = rd2_p1;
    endcase
  end

  assign SrcA_o        = fwd_a;
  assign SrcB_o        = alu_src_p1 ? imm_p1 : fwd_b;
  assign WriteData_E_o = fwd_b;
  assign ALUControl_o  = alu_ctrl_p1;
  assign Rd_E_o        = rd_p1;
  assign PC_E_o        = pc_p1;
  assign ImmExt_E_o    = imm_p1;
  assign RegWrite_E_o  = reg_write_p1;
  assign MemWrite_E_o  = mem_write_p1;
  assign ResultSrc_E_o = result_src_p1;
  assign Branch_E_o    = branch_p1;
  assign Jump_E_o      = jump_p1;
  assign Valid_E_o     = vld_p1;
  assign Stall_D_o     = load_use;
  assign BubbleCnt_o   = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, forwarding, load-use, flush, reset, counter saturation.
module tb_id_ex_stage;

  logic        clk, rst;
  logic        Valid_D;
  logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_D;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic [2:0]  ALUControl_D;
  logic        ALUSrc_D, RegWrite_D, MemWrite_D, Branch_D, Jump_D;
  logic [1:0]  ResultSrc_D;
  logic        RegWrite_M, RegWrite_W, Flush_E;
  logic [4:0]  Rd_M, Rd_W;
  logic [31:0] ALUResult_M, Result_W;

  logic [31:0] SrcA, SrcB, WriteData_E, PC_E, ImmExt_E;
  logic [2:0]  ALUControl;
  logic [4:0]  Rd_E;
  logic        RegWrite_E, MemWrite_E, Branch_E, Jump_E, Valid_E, Stall_D;
  logic [1:0]  ResultSrc_E;
  logic [15:0] BubbleCnt;

  logic [31:0] s_SrcA, s_SrcB, s_WriteData_E, s_PC_E, s_ImmExt_E;
  logic [2:0]  s_ALUControl;
  logic [4:0]  s_Rd_E;
  logic        s_RegWrite_E, s_MemWrite_E, s_Branch_E, s_Jump_E, s_Valid_E, s_Stall_D;
  logic [1:0]  s_ResultSrc_E;
  logic [3:0]  s_BubbleCnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .Valid_D_i(Valid_D), .RD1_D_i(RD1_D), .RD2_D_i(RD2_D),
    .Rs1_D_i(Rs1_D), .Rs2_D_i(Rs2_D), .Rd_D_i(Rd_D), .ImmExt_D_i(ImmExt_D), .PC_D_i(PC_D),
    .ALUControl_D_i(ALUControl_D), .ALUSrc_D_i(ALUSrc_D), .RegWrite_D_i(RegWrite_D),
    .MemWrite_D_i(MemWrite_D), .ResultSrc_D_i(ResultSrc_D), .Branch_D_i(Branch_D),
    .Jump_D_i(Jump_D), .RegWrite_M_i(RegWrite_M), .Rd_M_i(Rd_M), .ALUResult_M_i(ALUResult_M),
    .RegWrite_W_i(RegWrite_W), .Rd_W_i(Rd_W), .Result_W_i(Result_W), .Flush_E_i(Flush_E),
    .SrcA_o(SrcA), .SrcB_o(SrcB), .ALUControl_o(ALUControl), .WriteData_E_o(WriteData_E),
    .Rd_E_o(Rd_E), .PC_E_o(PC_E), .ImmExt_E_o(ImmExt_E), .RegWrite_E_o(RegWrite_E),
    .MemWrite_E_o(MemWrite_E), .ResultSrc_E_o(ResultSrc_E), .Branch_E_o(Branch_E),
    .Jump_E_o(Jump_E), .Valid_E_o(Valid_E), .Stall_D_o(Stall_D), .BubbleCnt_o(BubbleCnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .Valid_D_i(Valid_D), .RD1_D_i(RD1_D), .RD2_D_i(RD2_D),
    .Rs1_D_i(Rs1_D), .Rs2_D_i(Rs2_D), .Rd_D_i(Rd_D), .ImmExt_D_i(ImmExt_D), .PC_D_i(PC_D),
    .ALUControl_D_i(ALUControl_D), .ALUSrc_D_i(ALUSrc_D), .RegWrite_D_i(RegWrite_D),
    .MemWrite_D_i(MemWrite_D), .ResultSrc_D_i(ResultSrc_D), .Branch_D_i(Branch_D),
    .Jump_D_i(Jump_D), .RegWrite_M_i(RegWrite_M), .Rd_M_i(Rd_M), .ALUResult_M_i(ALUResult_M),
    .RegWrite_W_i(RegWrite_W), .Rd_W_i(Rd_W), .Result_W_i(Result_W), .Flush_E_i(Flush_E),
    .SrcA_o(s_SrcA), .SrcB_o(s_SrcB), .ALUControl_o(s_ALUControl), .WriteData_E_o(s_WriteData_E),
    .Rd_E_o(s_Rd_E), .PC_E_o(s_PC_E), .ImmExt_E_o(s_ImmExt_E), .RegWrite_E_o(s_RegWrite_E),
    .MemWrite_E_o(s_MemWrite_E), .ResultSrc_E_o(s_ResultSrc_E), .Branch_E_o(s_Branch_E),
    .Jump_E_o(s_Jump_E), .Valid_E_o(s_Valid_E), .Stall_D_o(s_Stall_D), .BubbleCnt_o(s_BubbleCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [2:0] op, input logic asrc, input logic [31:0] imm,
                       input logic rw, input logic [1:0] rsrc);
    Valid_D = v; Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd; RD1_D = r1; RD2_D = r2;
    ALUControl_D = op; ALUSrc_D = asrc; ImmExt_D = imm; RegWrite_D = rw; ResultSrc_D = rsrc;
  endtask

  initial begin
    clk = 0; rst = 1; Flush_E = 0;
    set_d(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00);
    PC_D = 0; MemWrite_D = 0; Branch_D = 0; Jump_D = 0;
    RegWrite_M = 0; Rd_M = 0; ALUResult_M = 0; RegWrite_W = 0; Rd_W = 0; Result_W = 0;
    #2;
    chk("rst_srca", SrcA, 0);
    chk("rst_srcb", SrcB, 0);
    chk("rst_aluctl", ALUControl, 0);
    chk("rst_rd", Rd_E, 0);
    chk("rst_valid", Valid_E, 0);
    chk("rst_cnt", BubbleCnt, 0);
    rst = 0; #1;

    // pass-through
    set_d(1, 1, 2, 3, 5, 7, 3'b000, 0, 0, 1, 2'b00);
    PC_D = 32'h100;
    tick();
    chk("pt_srca", SrcA, 5);
    chk("pt_srcb", SrcB, 7);
    chk("pt_aluctl", ALUControl, 0);
    chk("pt_rd", Rd_E, 3);
    chk("pt_pc", PC_E, 32'h100);
    chk("pt_valid", Valid_E, 1);
    chk("pt_regwrite", RegWrite_E, 1);
    chk("pt_stall", Stall_D, 0);
    set_d(1, 1, 2, 3, 5, 7, 3'b000, 1, 32'hFFFF_FFFC, 1, 2'b00);
    tick();
    chk("imm_srcb", SrcB, 32'hFFFF_FFFC);
    chk("imm_wdata", WriteData_E, 7);
    chk("imm_immext", ImmExt_E, 32'hFFFF_FFFC);

    // forwarding
    set_d(1, 4, 4, 8, 32'h99, 32'h98, 3'b001, 1, 8, 1, 2'b00);
    tick();
    RegWrite_M = 1; Rd_M = 4; ALUResult_M = 32'h11;
    RegWrite_W = 1; Rd_W = 4; Result_W = 32'h22;
    #1;
    chk("fwd_mem_a", SrcA, 32'h11);
    chk("fwd_mem_b_imm", SrcB, 8);
    chk("fwd_mem_wdata", WriteData_E, 32'h11);
    chk("fwd_aluctl_sub", ALUControl, 3'b001);
    RegWrite_M = 0; #1;
    chk("fwd_wb_a", SrcA, 32'h22);
    chk("fwd_wb_wdata", WriteData_E, 32'h22);
    RegWrite_W = 0; #1;
    chk("fwd_none_a", SrcA, 32'h99);
    set_d(1, 0, 0, 9, 32'h55, 32'h56, 3'b000, 0, 0, 1, 2'b00);
    tick();
    RegWrite_M = 1; Rd_M = 0; RegWrite_W = 1; Rd_W = 0; #1;
    chk("fwd_x0_a", SrcA, 32'h55);
    chk("fwd_x0_b", SrcB, 32'h56);
    RegWrite_M = 0; RegWrite_W = 0;

    // load-use: lw x5 then add x6,x5,x1
    set_d(1, 2, 0, 5, 32'h40, 0, 3'b000, 1, 4, 1, 2'b01);
    tick();
    set_d(1, 5, 1, 6, 32'hAAA, 3, 3'b000, 0, 0, 1, 2'b00);
    #1;
    chk("lu_stall", Stall_D, 1);
    tick();
    chk("lu_bub_valid", Valid_E, 0);
    chk("lu_bub_cnt", BubbleCnt, 1);
    chk("lu_bub_regwrite", RegWrite_E, 0);
    chk("lu_stall_clear", Stall_D, 0);
    RegWrite_M = 1; Rd_M = 5; ALUResult_M = 32'h1234;
    tick();
    chk("lu_add_valid", Valid_E, 1);
    chk("lu_add_rd", Rd_E, 6);
    chk("lu_add_srca", SrcA, 32'h1234);
    chk("lu_add_srcb", SrcB, 3);
    chk("lu_cnt_hold", BubbleCnt, 1);
    RegWrite_M = 0; Rd_M = 0;

    // flush and stall together
    set_d(1, 2, 0, 7, 0, 0, 3'b000, 1, 0, 1, 2'b01);
    MemWrite_D = 0; Branch_D = 0; Jump_D = 0;
    tick();
    set_d(1, 1, 7, 10, 1, 2, 3'b011, 0, 0, 1, 2'b00);
    MemWrite_D = 1; Branch_D = 1; Jump_D = 1;
    Flush_E = 1; #1;
    chk("fs_stall", Stall_D, 1);
    tick();
    Flush_E = 0;
    chk("fs_valid", Valid_E, 0);
    chk("fs_cnt", BubbleCnt, 2);
    chk("fs_regwrite", RegWrite_E, 0);
    chk("fs_memwrite", MemWrite_E, 0);
    chk("fs_ressrc", ResultSrc_E, 0);
    chk("fs_branch", Branch_E, 0);
    chk("fs_jump", Jump_E, 0);
    chk("fs_aluctl", ALUControl, 0);

    // empty decode slot
    set_d(0, 1, 2, 11, 1, 2, 3'b001, 1, 0, 1, 2'b10);
    tick();
    chk("nv_valid", Valid_E, 0);
    chk("nv_regwrite", RegWrite_E, 0);
    chk("nv_aluctl", ALUControl, 0);
    chk("nv_branch", Branch_E, 0);
    chk("nv_cnt", BubbleCnt, 2);
    MemWrite_D = 0; Branch_D = 0; Jump_D = 0;

    // asynchronous reset mid-stream, clock held low
    set_d(1, 2, 0, 9, 0, 0, 3'b000, 1, 0, 1, 2'b01);
    PC_D = 32'h200;
    tick();
    set_d(1, 9, 0, 12, 0, 0, 3'b000, 0, 0, 1, 2'b00);
    #1;
    chk("ar_stall_pre", Stall_D, 1);
    chk("ar_pc_pre", PC_E, 32'h200);
    rst = 1; #1;
    chk("ar_valid", Valid_E, 0);
    chk("ar_stall", Stall_D, 0);
    chk("ar_cnt", BubbleCnt, 0);
    chk("ar_pc", PC_E, 0);
    chk("ar_rd", Rd_E, 0);
    rst = 0; #1;

    // saturation
    Flush_E = 1;
    for (int i = 0; i < 20; i++) tick();
    Flush_E = 0;
    chk("sat_cnt16", BubbleCnt, 20);
    chk("sat_cnt4", s_BubbleCnt, 4'hF);
    tick();
    chk("sat_cnt4_hold", s_BubbleCnt, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
